// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage and IF/ID pipeline register.
//
// The unit owns the program counter and fetches over a request/ready
// instruction-memory port. Each fetched word is written, with its PC, into the
// IF/ID register that feeds decode. If decode is stalled when a response
// arrives, the word goes into a one-entry skid buffer. No new request is
// issued until that buffer has drained.
//
// Optional build macro: DELAY_SLOT_EN
//   defined   : MIPS-style branch delay slot. On a redirect, the word at
//               branch_pc+4 (in flight or buffered) is still delivered, and the
//               PC jumps to the target after that fetch completes.
//   undefined : a redirect kills IF/ID, the skid buffer and any in-flight fetch
//               (the DROP state discards the late response). The next
//               delivered word is the one at the target.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   imem_req/addr     fetch request; held, with a stable address, until
//                     accepted
//   imem_ready/rdata  request accepted, and the instruction word valid, this
//                     cycle
//   stall             decode stall: IF/ID is frozen and no new fetch is
//                     launched
//   flush             invalidate IF/ID and the skid buffer; the PC is
//                     untouched
//   redirect/target   branch or jump resolved in decode (ignored while stalled)
//   id_inst/id_pc     IF/ID contents
//   id_pc_plus4       id_pc + 4
//   id_valid          IF/ID holds a real instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  // BOOT : one idle cycle after reset
  // REQ  : request at pc, back-to-back while the skid buffer is empty
  // HOLD : skid buffer occupied, request lowered until it drains
  // DROP : waiting out a killed fetch whose response must be discarded
  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_HOLD,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  logic        req_active;  // a request is on the port this cycle
  logic        resp_ok;     // an accepted response that carries real data
  logic        redir;       // redirect that takes effect this cycle
  logic [31:0] next_pc;     // PC after an accepted fetch

  // Outputs depend only on flops, so stall, flush and redirect have no
  // combinational path to the memory port.
  assign req_active  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_req    = req_active;
  assign imem_addr   = pc_q;

  assign resp_ok     = (state_q == S_REQ) && imem_ready;
  assign redir       = redirect && !stall;
  assign next_pc     = pend_valid_q ? pend_target_q : (pc_q + PC_INC);

  assign id_inst     = id_inst_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_q + 32'd4;
  assign id_valid    = id_valid_q;

  // NOTE: every *_d gets its hold value first, so no path through this block
  // can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    buf_valid_d   = buf_valid_q;
    buf_inst_d    = buf_inst_q;
    buf_pc_d      = buf_pc_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_valid_d    = id_valid_q;

    // ---- PC and fetch sequencing ------------------------------------------
    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          pc_d         = next_pc;
          pend_valid_d = 1'b0;
        end
      end
      S_HOLD: ;
      S_DROP: begin
        if (imem_ready) begin
          pc_d         = pend_target_q;
          pend_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
    endcase

    // ---- IF/ID register and skid buffer -----------------------------------
    // The buffer is always empty in REQ, so a response never collides with
    // a buffered word.
    if (resp_ok && stall) begin
      buf_inst_d  = imem_rdata;
      buf_pc_d    = pc_q;
      buf_valid_d = 1'b1;
    end

    if (!stall) begin
      if (resp_ok) begin
        id_inst_d  = imem_rdata;
        id_pc_d    = pc_q;
        id_valid_d = 1'b1;
      end else if (buf_valid_q) begin
        id_inst_d   = buf_inst_q;
        id_pc_d     = buf_pc_q;
        id_valid_d  = 1'b1;
        buf_valid_d = 1'b0;
      end else begin
        id_valid_d = 1'b0;
      end
    end

    // ---- redirect from decode ---------------------------------------------
    if (redir) begin
      if (req_active && !imem_ready) begin
        // The in-flight fetch must complete before the PC can move.
        pend_target_d = redirect_target;
        pend_valid_d  = 1'b1;
`ifndef DELAY_SLOT_EN
        state_d       = S_DROP;
`endif
      end else begin
        // Nothing outstanding, or the fetch completes on this edge.
        pc_d         = redirect_target;
        pend_valid_d = 1'b0;
      end
`ifndef DELAY_SLOT_EN
      // Everything fetched after the branch is wrong-path.
      buf_valid_d = 1'b0;
      id_valid_d  = 1'b0;
`endif
    end

    // ---- flush wins over stall and over any load above ----------------------
    if (flush) begin
      buf_valid_d = 1'b0;
      id_valid_d  = 1'b0;
    end

    // ---- request gating: REQ is entered only with an empty skid buffer ------
    if ((state_d == S_REQ) || (state_d == S_HOLD)) begin
      state_d = buf_valid_d ? S_HOLD : S_REQ;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, whatever order the simulator runs blocks in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      buf_valid_q   <= 1'b0;
      id_inst_q     <= '0;
      id_pc_q       <= '0;
      id_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      buf_valid_q   <= buf_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_valid_q    <= id_valid_d;
    end
  end

  // NOTE: the buffer payload has no reset. buf_valid_q gates every use of it,
  // so leaving the data flops out of the reset network costs nothing.
  always_ff @(posedge clk) begin
    buf_inst_q <= buf_inst_d;
    buf_pc_q   <= buf_pc_d;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed steps walk through boot, back-to-back fetch, a stall with skid
// buffering, a redirect, flush during stall, and reset mid-request. A second
// instance with RESET_PC = 0xFFFF_FFFC covers PC wrap-around.
//
// A randomized phase then drives random ready, stall and redirect. The decode
// side consumes IF/ID on every edge where stall=0 and id_valid=1. Each consumed
// word is checked against the expected program-order stream: sequential +4,
// with branches jumping to their target (after one delay-slot word when
// DELAY_SLOT_EN is defined).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: RESET_PC = 0
  logic        rst, imem_ready, stall, flush, redirect;
  logic [31:0] imem_rdata, redirect_target;
  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_inst, id_pc, id_pc_plus4;

  // instance B: RESET_PC = 0xFFFF_FFFC, always ready, never stalled
  logic        rst_b, ready_b, tie_lo;
  logic [31:0] rdata_b, tie_lo32;
  logic        req_b, id_valid_b;
  logic [31:0] addr_b, id_inst_b, id_pc_b, id_pc_plus4_b;

  int total = 0;
  int bad   = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_target(redirect_target),
    .id_inst(id_inst), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst_b),
    .imem_req(req_b), .imem_addr(addr_b),
    .imem_ready(ready_b), .imem_rdata(rdata_b),
    .stall(tie_lo), .flush(tie_lo),
    .redirect(tie_lo), .redirect_target(tie_lo32),
    .id_inst(id_inst_b), .id_pc(id_pc_b), .id_pc_plus4(id_pc_plus4_b),
    .id_valid(id_valid_b)
  );

  // Instruction memory contents: each word encodes its own address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h2008_0000 | a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Advance one cycle. Outputs are sampled and inputs driven at the falling
  // edge, and the memory answers for whatever address is now presented.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    imem_rdata = word_at(imem_addr);
    rdata_b    = word_at(addr_b);
  endtask

  logic [31:0] exp_pc, ds_tgt;
  bit          ds_pend, may_branch, prev_hold;
  logic [31:0] prev_addr;
  int          consumed;

  initial begin
    rst = 1'b1; rst_b = 1'b1; imem_ready = 1'b0; ready_b = 1'b1;
    stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_target = '0;
    imem_rdata = '0; rdata_b = '0; tie_lo = 1'b0; tie_lo32 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; rst_b = 1'b0;
    imem_rdata = word_at(imem_addr);
    rdata_b    = word_at(addr_b);

    // BOOT cycle straight after reset
    check("rst_req",    imem_req,    0);
    check("rst_addr",   imem_addr,   32'h0);
    check("rst_valid",  id_valid,    0);
    check("rst_inst",   id_inst,     32'h0);
    check("rst_pc",     id_pc,       32'h0);
    check("rst_pc4",    id_pc_plus4, 32'h4);
    check("b_rst_req",  req_b,       0);

    imem_ready = 1'b1;
    step();
    check("f0_req",     imem_req,    1);
    check("f0_addr",    imem_addr,   32'h0);
    check("f0_valid",   id_valid,    0);
    check("b_addr0",    addr_b,      32'hFFFF_FFFC);
    check("b_req",      req_b,       1);
    step();
    check("f1_addr",    imem_addr,   32'h4);
    check("f1_valid",   id_valid,    1);
    check("f1_pc",      id_pc,       32'h0);
    check("f1_inst",    id_inst,     32'h2008_0000);
    check("f1_pc4",     id_pc_plus4, 32'h4);
    check("b_wrap",     addr_b,      32'h0);
    check("b_idpc",     id_pc_b,     32'hFFFF_FFFC);
    check("b_idinst",   id_inst_b,   32'hFFFF_FFFC);
    check("b_idpc4",    id_pc_plus4_b, 32'h0);
    check("b_idvalid",  id_valid_b,  1);
    step();
    check("f2_addr",    imem_addr,   32'h8);
    check("f2_pc",      id_pc,       32'h4);

    // three stall cycles while the word at 8 is accepted
    stall = 1'b1;
    step();
    check("st1_req",    imem_req,    0);
    check("st1_pc",     id_pc,       32'h4);
    check("st1_valid",  id_valid,    1);
    step();
    check("st2_req",    imem_req,    0);
    check("st2_pc",     id_pc,       32'h4);
    step();
    check("st3_req",    imem_req,    0);
    check("st3_pc",     id_pc,       32'h4);
    stall = 1'b0;
    step();
    check("drn_pc",     id_pc,       32'h8);
    check("drn_inst",   id_inst,     32'h2008_0008);
    check("drn_req",    imem_req,    1);
    check("drn_addr",   imem_addr,   32'hC);
    step();
    check("nx_pc",      id_pc,       32'hC);
    check("nx_valid",   id_valid,    1);
    check("nx_addr",    imem_addr,   32'h10);

    // redirect to 0x40 while the fetch at 0x10 is outstanding
    imem_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h40;
    step();
    check("rd_req",     imem_req,    1);
    check("rd_addr",    imem_addr,   32'h10);
    check("rd_valid",   id_valid,    0);
    redirect = 1'b0; imem_ready = 1'b1;
    step();
    check("rd1_addr",   imem_addr,   32'h40);
`ifdef DELAY_SLOT_EN
    check("rd1_valid",  id_valid,    1);
    check("rd1_pc",     id_pc,       32'h10);
`else
    check("rd1_valid",  id_valid,    0);
`endif
    step();
    check("rd2_pc",     id_pc,       32'h40);
    check("rd2_valid",  id_valid,    1);
    check("rd2_addr",   imem_addr,   32'h44);

    // flush together with stall while the word at 0x44 sits in the buffer
    stall = 1'b1;
    step();
    check("fl0_req",    imem_req,    0);
    check("fl0_pc",     id_pc,       32'h40);
    flush = 1'b1;
    step();
    check("fl_valid",   id_valid,    0);
    check("fl_req",     imem_req,    1);
    check("fl_addr",    imem_addr,   32'h48);
    flush = 1'b0; stall = 1'b0;
    step();
    check("fl2_pc",     id_pc,       32'h48);
    check("fl2_valid",  id_valid,    1);

    // reset while the request at 0x4C is outstanding
    imem_ready = 1'b0;
    step();
    check("mr_req",     imem_req,    1);
    check("mr_addr",    imem_addr,   32'h4C);
    rst = 1'b1;
    step();
    check("mr_rst_req", imem_req,    0);
    check("mr_rst_val", id_valid,    0);
    rst = 1'b0; imem_ready = 1'b1;
    step();
    check("mr_addr0",   imem_addr,   32'h0);
    check("mr_req1",    imem_req,    1);
    check("mr_valid",   id_valid,    0);

    // randomized phase: program-order stream scoreboard
    exp_pc = 32'h0; ds_pend = 1'b0; ds_tgt = '0; consumed = 0;
    prev_hold = 1'b0; prev_addr = '0;
    for (int i = 0; i < 3000; i++) begin
      if (prev_hold && imem_req) check("addr_stable", imem_addr, prev_addr);
      stall      = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      redirect   = 1'b0;
      if (!stall && id_valid) begin
        check("stream_pc",   id_pc,       exp_pc);
        check("stream_inst", id_inst,     word_at(exp_pc));
        check("stream_pc4",  id_pc_plus4, exp_pc + 32'd4);
        consumed++;
        may_branch = !ds_pend;
        if (ds_pend) begin
          exp_pc  = ds_tgt;
          ds_pend = 1'b0;
        end else begin
          exp_pc = exp_pc + 32'd4;
        end
        if (may_branch && ($urandom_range(0, 7) == 0)) begin
          redirect        = 1'b1;
          redirect_target = $urandom & 32'hFFFF_FFFC;
`ifdef DELAY_SLOT_EN
          ds_pend = 1'b1;
          ds_tgt  = redirect_target;
`else
          exp_pc  = redirect_target;
`endif
        end
      end
      prev_hold = imem_req && !imem_ready;
      prev_addr = imem_addr;
      step();
    end
    redirect = 1'b0; stall = 1'b0;
    check("progress", (consumed >= 500) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
